// File: rtl/booth_mult_r4.sv
// Radix-4 modified Booth sequential multiplier, DW x DW -> 2*DW, signed or unsigned per operation.
// Operands are extended by two bits so the unsigned full range and an even digit count come for free.
module booth_mult_r4 #(
    parameter int DW = 8,
    parameter int CW = $clog2(DW/2+2)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic              i_signed,
    input  logic              i_abort,
    input  logic [DW-1:0]     i_multiplier,
    input  logic [DW-1:0]     i_multiplicand,
    output logic [2*DW-1:0]   o_product,
    output logic              o_rdy,
    output logic              o_busy,
    output logic [CW-1:0]     o_cnt,
    output logic [1:0]        o_state
);

    localparam int AW = DW + 4;
    localparam int QW = DW + 2;
    localparam logic [CW-1:0] N_ITER = CW'(DW/2 + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_next;

    logic [AW-1:0]   acc;
    logic [QW-1:0]   q;
    logic            q_m1;
    logic [AW-1:0]   mx;
    logic [CW-1:0]   cnt;
    logic [2*DW-1:0] product;

    logic            load;
    logic            step;
    logic            finish;
    logic            clear_cnt;

    logic [QW-1:0]   ext_q;
    logic [AW-1:0]   ext_m;
    logic [AW-1:0]   addend;
    logic [AW-1:0]   acc_sum;
    logic [AW-1:0]   acc_shift;
    logic [QW-1:0]   q_shift;

    always_comb begin
        ext_q = i_signed ? {{2{i_multiplier[DW-1]}}, i_multiplier}
                         : {2'b00, i_multiplier};
        ext_m = i_signed ? {{4{i_multiplicand[DW-1]}}, i_multiplicand}
                         : {4'b0000, i_multiplicand};
    end

    // Booth digit in {-2,-1,0,+1,+2} applied to the extended multiplicand
    always_comb begin
        addend = '0;
        unique case ({q[1:0], q_m1})
            3'b001, 3'b010: addend = mx;
            3'b011:         addend = mx << 1;
            3'b100:         addend = -(mx << 1);
            3'b101, 3'b110: addend = -mx;
            default:        addend = '0;
        endcase
    end

    always_comb begin
        acc_sum   = acc + addend;
        acc_shift = {{2{acc_sum[AW-1]}}, acc_sum[AW-1:2]};
        q_shift   = {acc_sum[1:0], q[QW-1:2]};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        finish     = 1'b0;
        clear_cnt  = 1'b0;
        unique case (state)
            IDLE: begin
                if (i_start) begin
                    load       = 1'b1;
                    state_next = CALC;
                end
            end
            CALC: begin
                if (i_abort) begin
                    clear_cnt  = 1'b1;
                    state_next = IDLE;
                end else begin
                    step = 1'b1;
                    if (cnt == CW'(1)) begin
                        finish     = 1'b1;
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                if (i_start) begin
                    load       = 1'b1;
                    state_next = CALC;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc     <= '0;
            q       <= '0;
            q_m1    <= 1'b0;
            mx      <= '0;
            cnt     <= '0;
            product <= '0;
        end else if (load) begin
            acc  <= '0;
            q    <= ext_q;
            q_m1 <= 1'b0;
            mx   <= ext_m;
            cnt  <= N_ITER;
        end else if (step) begin
            acc  <= acc_shift;
            q    <= q_shift;
            q_m1 <= q[1];
            cnt  <= cnt - CW'(1);
            // Low 2*DW bits of {A,Q} after the final shift
            if (finish) begin
                product <= {acc_shift[DW-3:0], q_shift};
            end
        end else if (clear_cnt) begin
            cnt <= '0;
        end
    end

    assign o_product = product;
    assign o_rdy     = (state == DONE);
    assign o_busy    = (state == CALC);
    assign o_cnt     = cnt;
    assign o_state   = state;

endmodule
